// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake bundle between InvShiftRows, the iterative InvSubBytes stage and AddRoundKey.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Upstream/downstream side: drives blocks in and accepts results
    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

    // Stage side
    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage: LANES inverse S-boxes walk the 16 state bytes, byte 0 first.
// Latency: accept at edge T -> out_valid after edge T+16/LANES; one block per 16/LANES+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Optional INV_SUB_BYTES_SHIFT_ROWS_EN folds InvShiftRows into the capture step.

// One inverse S-box lookup; pure combinational table.
module inv_sbox_element (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry for code x sits at packed index 255-x, i.e. ~x.
    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[~in_byte];
endmodule

module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    inv_sub_bytes_iter_if.slave bus
);
    localparam int K     = 16 / LANES;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int LOG_L = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // Byte i of the AES state lives at data_q[15-i], matching in_state[127-8i -: 8].
    logic [15:0][7:0]  data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        lane_idx [LANES];
    logic [7:0]        lane_in  [LANES];
    logic [7:0]        lane_out [LANES];

    // Byte layout loaded into the data register on accept.
    function automatic logic [15:0][7:0] capture_map(input logic [15:0][7:0] x);
        logic [15:0][7:0] y;
`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
        // Row r rotated right by r columns: s'[r][c] = in[r][(c-r) mod 4].
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[4'(15 - (4 * c + r))] = x[4'(15 - (4 * ((c - r + 4) % 4) + r))];
            end
        end
`else
        y = x;
`endif
        return y;
    endfunction

    // Select the LANES bytes handled this cycle: byte cnt*LANES + l.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = (4'(cnt_q) << LOG_L) | 4'(l);
            lane_in[l]  = data_q[~lane_idx[l]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_element u_sbox (
            .in_byte  (lane_in[g]),
            .out_byte (lane_out[g])
        );
    end

    // FSM next state, data write-back and byte counter.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    data_d  = capture_map(bus.in_state);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[~lane_idx[l]] = lane_out[l];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from registers; in_ready is also held low during reset.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
